// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory
// and loads the IF/ID register, with a one-entry hold buffer that covers stalls.
module fetch_ifid_stage #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP      = 'h13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    output logic [N-1:0] imem_addr,
    output logic         imem_en,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] ifid_pc,
    output logic [N-1:0] ifid_instr,
    output logic         ifid_valid
);

    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    logic [N-1:0] pc_f;
    logic         req_valid;
    logic [N-1:0] req_pc;
    logic         hold_valid;
    logic [N-1:0] hold_instr;
    logic [N-1:0] hold_pc;

    logic [N-1:0] pc_f_n;
    logic         req_valid_n;
    logic [N-1:0] req_pc_n;
    logic         hold_valid_n;
    logic [N-1:0] hold_instr_n;
    logic [N-1:0] hold_pc_n;
    logic [N-1:0] ifid_pc_n;
    logic [N-1:0] ifid_instr_n;
    logic         ifid_valid_n;

    assign imem_addr = pc_f;
    assign imem_en   = !rst && !stall && !redirect;

    always_comb begin
        pc_f_n       = pc_f;
        req_valid_n  = req_valid;
        req_pc_n     = req_pc;
        hold_valid_n = hold_valid;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        ifid_pc_n    = ifid_pc;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;

        if (redirect) begin
            // Discard both the in-flight request and any held instruction.
            pc_f_n       = redirect_target & ALIGN_MASK;
            req_valid_n  = 1'b0;
            hold_valid_n = 1'b0;
            ifid_pc_n    = '0;
            ifid_instr_n = NOP;
            ifid_valid_n = 1'b0;
        end else if (stall) begin
            // Memory data for last cycle's request arrives now; park it so it is not lost.
            if (req_valid) begin
                hold_valid_n = 1'b1;
                hold_instr_n = imem_rdata;
                hold_pc_n    = req_pc;
            end
            req_valid_n = 1'b0;
        end else begin
            if (hold_valid) begin
                ifid_pc_n    = hold_pc;
                ifid_instr_n = hold_instr;
                ifid_valid_n = 1'b1;
            end else if (req_valid) begin
                ifid_pc_n    = req_pc;
                ifid_instr_n = imem_rdata;
                ifid_valid_n = 1'b1;
            end else begin
                ifid_pc_n    = '0;
                ifid_instr_n = NOP;
                ifid_valid_n = 1'b0;
            end
            hold_valid_n = 1'b0;
            req_valid_n  = 1'b1;
            req_pc_n     = pc_f;
            pc_f_n       = pc_f + PC_STEP;
        end
    end

    // Fetch control and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f       <= RESET_PC;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else begin
            pc_f       <= pc_f_n;
            req_valid  <= req_valid_n;
            hold_valid <= hold_valid_n;
            ifid_pc    <= ifid_pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

    // Request and hold payloads are qualified by their valid bits and need no reset.
    always_ff @(posedge clk) begin
        req_pc     <= req_pc_n;
        hold_instr <= hold_instr_n;
        hold_pc    <= hold_pc_n;
    end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register that feed the decode stage and the hazard unit.
- Owns the PC register and drives a synchronous instruction memory with a fixed 1-cycle read latency.
- Captures the fetched instruction and its PC into the IF/ID register.
- Obeys stall requests from the hazard unit and redirect/flush requests from the branch logic.
- A one-entry hold buffer ensures an instruction returning from memory during a stall is never lost or fetched twice.

Parameters:
N, 32, data/address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP, 32'h0000_0013, instruction inserted into IF/ID on bubble or flush (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
stall  input  1  hazard-unit request: freeze PC and IF/ID this cycle.
redirect  input  1  branch/jump taken: flush and refetch from redirect_target.
redirect_target  input  N  new fetch address; bits [1:0] are ignored (forced to 0).
imem_addr  output  N  fetch address, equal to pc_f.
imem_en  output  1  read strobe; data for that address returns on imem_rdata next cycle.
imem_rdata  input  N  instruction data, valid the cycle after imem_en was high.
ifid_pc  output  N  PC of the instruction in IF/ID.
ifid_instr  output  N  instruction in IF/ID.
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Internal state:
  - pc_f: next address to request.
  - req_valid, req_pc: request in flight last cycle.
  - hold_valid, hold_instr, hold_pc: one-entry hold buffer.
- Outputs:
  - imem_addr = pc_f, combinational.
  - imem_en = !rst && !stall && !redirect.
- Reset (rst=1 at an edge):
  - pc_f <= RESET_PC; req_valid <= 0; hold_valid <= 0.
  - ifid_pc <= 0; ifid_instr <= NOP; ifid_valid <= 0.
  - Reset overrides all other inputs, including mid-stall or mid-redirect.
- Priority per edge: rst > redirect > stall > normal.
- Redirect:
  - pc_f <= {redirect_target[N-1:2], 2'b00}.
  - req_valid <= 0 and hold_valid <= 0, so in-flight and held instructions are discarded.
  - IF/ID <= {pc 0, NOP, valid 0}.
  - Redirect overrides a simultaneous stall.
- Stall (stall=1, redirect=0):
  - pc_f and IF/ID are unchanged; imem_en=0, so no new request is issued.
  - If req_valid=1: hold_instr <= imem_rdata, hold_pc <= req_pc, hold_valid <= 1.
  - req_valid <= 0.
  - An already-full hold buffer is preserved across multi-cycle stalls. It cannot be overwritten, because req_valid is 0 after the first stall cycle.
- Normal (stall=0, redirect=0):
  - IF/ID load source, in priority order:
    - If hold_valid: load the hold entry (valid 1), then hold_valid <= 0.
    - Else if req_valid: load {req_pc, imem_rdata, 1}.
    - Else: load {0, NOP, 0}.
  - req_pc <= pc_f; req_valid <= 1; pc_f <= pc_f + 4 (wraps modulo 2^N).
- Invariant: hold_valid and req_valid are never both 1 on a normal cycle, so no instruction is dropped.
- Latency:
  - Address presented in cycle t reaches IF/ID (ifid_valid=1) in cycle t+2.
  - First instruction after rst deasserts: ifid_valid=1 two cycles later, with ifid_pc = RESET_PC.
  - Redirect asserted in cycle t: imem_addr = target in t+1; target instruction in IF/ID in t+3.
- Stall release: the held instruction enters IF/ID on the first non-stall edge. The next sequential instruction follows on the following edge with no bubble and no duplicate.
- Instruction order in IF/ID always matches program order: each ifid_pc is the previous valid ifid_pc + 4, except after a redirect.

Test Plan:
1. Reset then free-run with imem returning word = address: after rst drop, ifid_valid=1 in cycle 2 with pc 0x0, instr 0x0; following cycles show pc 0x4, 0x8, 0xC with no gaps.
2. Single-cycle stall while 0x8 is in flight: IF/ID holds pc 0x4 during the stall; the next edges load 0x8 then 0xC; no duplicate 0x8, no bubble.
3. Four-cycle stall: imem_en=0 for all four cycles; hold keeps 0x8; after release the sequence 0x8, 0xC, 0x10 is intact.
4. Redirect to 0x103 while the pipeline is streaming: IF/ID shows NOP/valid=0 next cycle; imem_addr=0x100; pc 0x100 appears in IF/ID three cycles after redirect; stale 0x8/0xC never appear.
5. redirect and stall asserted together while the hold buffer is full: redirect wins; hold is discarded; fetch resumes at the target.
6. Wrap-around with RESET_PC=32'hFFFF_FFFC: ifid_pc sequence is 0xFFFF_FFFC then 0x0000_0000. Separately, rst asserted mid-stall returns every output to its reset value on that edge.
